// File: rtl/run_ctl_pkg.sv
// Shared types for the CPU run-control sequencer: host command opcodes,
// sequencer states and the STEP count load rule.
package run_ctl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_RUN   = 3'd1,
    CMD_HALT  = 3'd2,
    CMD_STEP  = 3'd3,
    CMD_SETBP = 3'd4,
    CMD_RESET = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_e;

  localparam int unsigned STEP_W    = 16;
  localparam int unsigned BP_EN_BIT = 15;

  // A STEP of zero cycles is promoted to a single cycle.
  function automatic logic [STEP_W-1:0] step_load_val(input logic [15:0] n);
    logic [STEP_W-1:0] v;
    if (n == 16'd0) begin
      v = 16'd1;
    end else begin
      v = n;
    end
    return v;
  endfunction

endpackage

// File: rtl/run_ctl_downcnt.sv
// Loadable saturating down-counter with a zero flag; used for the CPU reset
// hold time and for the remaining STEP cycles.
module run_ctl_downcnt #(
  parameter int unsigned   W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_ctl.sv
// Run-control sequencer for the RV32I CPU: owns the CPU reset, the pipeline
// clock-enable, breakpoint halting and the enabled-cycle counter.
module cpu_run_ctl
  import run_ctl_pkg::*;
#(
  parameter int unsigned PC_W     = 12,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [15:0]      cmd_arg,
  input  logic [PC_W-1:0]  pc_F,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned      HOLD_W   = $clog2(HOLD_CYC) + 1;
  localparam logic [HOLD_W-1:0] HOLD_RST = HOLD_W'(HOLD_CYC - 1);

  state_e            state_q,     state_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              halted_q,    halted_d;
  logic              bp_hit_q,    bp_hit_d;
  logic              bp_en_q,     bp_en_d;
  logic [PC_W-1:0]   bp_addr_q,   bp_addr_d;
  logic              skip_bp_q,   skip_bp_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic              cmd_acc;
  logic              bp_match;
  logic              hold_load, hold_dec, hold_zero;
  logic [HOLD_W-1:0] hold_cnt_unused;
  logic              step_load, step_dec, step_zero, step_last;
  logic [STEP_W-1:0] step_cnt;

  run_ctl_downcnt #(.W(HOLD_W), .RST_VAL(HOLD_RST)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_RST),
    .dec      (hold_dec),
    .cnt      (hold_cnt_unused),
    .zero     (hold_zero)
  );

  run_ctl_downcnt #(.W(STEP_W), .RST_VAL(16'd0)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .load_val (step_load_val(cmd_arg)),
    .dec      (step_dec),
    .cnt      (step_cnt),
    .zero     (step_zero)
  );

  assign cmd_acc   = cmd_valid & cmd_ready_q;
  assign bp_match  = (state_q == S_RUN) & bp_en_q & (pc_F == bp_addr_q) & ~skip_bp_q;
  assign step_last = step_zero | (step_cnt == 16'd1);
  assign hold_dec  = (state_q == S_HOLD);
  assign step_dec  = (state_q == S_STEP);

  // Pipeline enable: a pending breakpoint freezes the CPU with pc_F unadvanced.
  always_comb begin
    case (state_q)
      S_RUN:   cpu_en = ~bp_match;
      S_STEP:  cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  // Next-state logic; RESET outranks breakpoints, which outrank HALT.
  always_comb begin
    state_d     = state_q;
    bp_hit_d    = bp_hit_q;
    skip_bp_d   = skip_bp_q;
    hold_load   = 1'b0;
    step_load   = 1'b0;
    cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en};

    if (cmd_acc && (cmd_op == CMD_SETBP)) begin
      bp_en_d   = cmd_arg[BP_EN_BIT];
      bp_addr_d = cmd_arg[PC_W-1:0];
    end else begin
      bp_en_d   = bp_en_q;
      bp_addr_d = bp_addr_q;
    end

    if (cmd_acc && (cmd_op == CMD_RESET)) begin
      state_d     = S_HOLD;
      hold_load   = 1'b1;
      cycle_cnt_d = '0;
      bp_hit_d    = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_zero) begin
            state_d = S_HALT;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HALT: begin
          if (cmd_acc && (cmd_op == CMD_RUN)) begin
            state_d   = S_RUN;
            skip_bp_d = 1'b1;
            bp_hit_d  = 1'b0;
          end else if (cmd_acc && (cmd_op == CMD_STEP)) begin
            state_d   = S_STEP;
            step_load = 1'b1;
            bp_hit_d  = 1'b0;
          end else begin
            state_d = S_HALT;
          end
        end
        S_RUN: begin
          skip_bp_d = 1'b0;
          if (bp_match) begin
            state_d  = S_HALT;
            bp_hit_d = 1'b1;
          end else if (cmd_acc && (cmd_op == CMD_HALT)) begin
            state_d = S_HALT;
          end else begin
            state_d = S_RUN;
          end
        end
        S_STEP: begin
          if (step_last || (cmd_acc && (cmd_op == CMD_HALT))) begin
            state_d = S_HALT;
          end else begin
            state_d = S_STEP;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end

    cpu_rst_n_d = (state_d != S_HOLD);
    cmd_ready_d = (state_d != S_HOLD);
    halted_d    = (state_d == S_HALT);
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      cpu_rst_n_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      halted_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_en_q     <= 1'b0;
      bp_addr_q   <= '0;
      skip_bp_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      cmd_ready_q <= cmd_ready_d;
      halted_q    <= halted_d;
      bp_hit_q    <= bp_hit_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
      skip_bp_q   <= skip_bp_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign halted    = halted_q;
  assign bp_hit    = bp_hit_q;
  assign state_o   = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Scoreboard bench for cpu_run_ctl: a cycle-level reference model pushes the
// expected outputs of each cycle, a monitor pops and compares on the falling edge.
module tb_cpu_run_ctl;
  import run_ctl_pkg::*;

  localparam int PC_W     = 12;
  localparam int HOLD_CYC = 4;

  typedef struct packed {
    logic [1:0]  st;
    logic        rst_n;
    logic        en;
    logic        ready;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd_op = 3'd0;
  logic [15:0]     cmd_arg = 16'd0;
  logic [PC_W-1:0] pc_F = '0;

  logic        cmd_ready, cpu_rst_n, cpu_en, halted, bp_hit;
  logic [1:0]  state_o;
  logic [31:0] cycle_cnt;
  logic        cmd_ready4, cpu_rst_n4, cpu_en4, halted4, bp_hit4;
  logic [1:0]  state_o4;
  logic [3:0]  cycle_cnt4;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  // reference model state
  state_e          m_mode;
  int              m_hold;
  int              m_steps;
  bit              m_bp_en, m_skip, m_bp_hit;
  logic [PC_W-1:0] m_bp_addr;
  logic [31:0]     m_cnt;
  logic [PC_W-1:0] cpu_pc;

  always #10 clk = ~clk;

  cpu_run_ctl #(.PC_W(PC_W), .HOLD_CYC(HOLD_CYC), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_F(pc_F), .cpu_rst_n(cpu_rst_n),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .state_o(state_o),
    .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctl #(.PC_W(PC_W), .HOLD_CYC(HOLD_CYC), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_F(pc_F), .cpu_rst_n(cpu_rst_n4),
    .cpu_en(cpu_en4), .halted(halted4), .bp_hit(bp_hit4), .state_o(state_o4),
    .cycle_cnt(cycle_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = S_HOLD; m_hold = HOLD_CYC; m_steps = 0;
    m_bp_en = 1'b0; m_bp_addr = '0; m_skip = 1'b0; m_bp_hit = 1'b0;
    m_cnt = 32'd0; cpu_pc = '0;
  endtask

  function automatic exp_t model_expect(input logic [PC_W-1:0] pc);
    exp_t e;
    e.st     = m_mode;
    e.rst_n  = (m_mode != S_HOLD);
    e.ready  = (m_mode != S_HOLD);
    e.halted = (m_mode == S_HALT);
    e.bp_hit = m_bp_hit;
    e.cnt    = m_cnt;
    e.en     = (m_mode == S_STEP) ||
               ((m_mode == S_RUN) && !(m_bp_en && (pc == m_bp_addr) && !m_skip));
    return e;
  endfunction

  task automatic model_advance(input bit v, input logic [2:0] op, input logic [15:0] arg,
                               input logic [PC_W-1:0] pc, input bit en);
    bit acc, hit;
    acc = v && (m_mode != S_HOLD);
    hit = (m_mode == S_RUN) && m_bp_en && (pc == m_bp_addr) && !m_skip;
    if (en) m_cnt = m_cnt + 32'd1;
    if (acc && op == 3'd5) begin
      m_mode = S_HOLD; m_hold = HOLD_CYC; m_cnt = 32'd0; m_bp_hit = 1'b0;
    end else begin
      if (acc && op == 3'd4) begin
        m_bp_en = arg[15]; m_bp_addr = arg[PC_W-1:0];
      end
      case (m_mode)
        S_HOLD: begin
          m_hold--;
          if (m_hold == 0) m_mode = S_HALT;
        end
        S_HALT: begin
          if (acc && op == 3'd1) begin
            m_mode = S_RUN; m_skip = 1'b1; m_bp_hit = 1'b0;
          end else if (acc && op == 3'd3) begin
            m_mode = S_STEP; m_steps = (arg == 16'd0) ? 1 : int'(arg); m_bp_hit = 1'b0;
          end
        end
        S_RUN: begin
          m_skip = 1'b0;
          if (hit) begin
            m_mode = S_HALT; m_bp_hit = 1'b1;
          end else if (acc && op == 3'd2) begin
            m_mode = S_HALT;
          end
        end
        default: begin
          m_steps--;
          if (m_steps == 0 || (acc && op == 3'd2)) m_mode = S_HALT;
        end
      endcase
    end
    // the bench's stand-in CPU fetches sequentially while enabled
    if (m_mode == S_HOLD) cpu_pc = '0;
    else if (en) cpu_pc = cpu_pc + PC_W'(1);
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic drive_cycle(input bit v, input logic [2:0] op, input logic [15:0] arg,
                             input bit rand_pc);
    exp_t e;
    cmd_valid = v; cmd_op = op; cmd_arg = arg;
    pc_F = rand_pc ? PC_W'($urandom_range(0, 31)) : cpu_pc;
    e = model_expect(pc_F);
    sb_q.push_back(e);
    model_advance(v, op, arg, pc_F, e.en);
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] arg);
    drive_cycle(1'b1, op, arg, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  // rst pulses for half a cycle, no clock edge sees it
  task automatic async_rst();
    exp_t e;
    rst = 1'b1;
    model_reset();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 16'd0; pc_F = cpu_pc;
    e = model_expect(pc_F);
    sb_q.push_back(e);
    model_advance(1'b0, 3'd0, 16'd0, pc_F, e.en);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // monitor: every falling edge the DUTs present one cycle's outputs
  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        me = sb_q.pop_front();
        chk("state_o",   32'(state_o),   32'(me.st));
        chk("cpu_rst_n", 32'(cpu_rst_n), 32'(me.rst_n));
        chk("cpu_en",    32'(cpu_en),    32'(me.en));
        chk("cmd_ready", 32'(cmd_ready), 32'(me.ready));
        chk("halted",    32'(halted),    32'(me.halted));
        chk("bp_hit",    32'(bp_hit),    32'(me.bp_hit));
        chk("cycle_cnt", cycle_cnt,      me.cnt);
        chk("dut4_outputs",
            32'({state_o4, cpu_rst_n4, cpu_en4, cmd_ready4, halted4, bp_hit4, cycle_cnt4}),
            32'({me.st, me.rst_n, me.en, me.ready, me.halted, me.bp_hit, me.cnt[3:0]}));
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [PC_W-1:0] bp_tmp;
    logic [15:0]     a;
    logic [2:0]      op;
    bit              v;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(6);                                   // hold then halt
    cmd(CMD_STEP, 16'd3);  idle(5);
    cmd(CMD_STEP, 16'd0);  idle(3);
    cmd(CMD_RESET, 16'd0); idle(5);            // pc back to 0
    cmd(CMD_SETBP, 16'h8010); cmd(CMD_RUN, 16'd0); idle(22);
    cmd(CMD_RUN, 16'd0);   idle(4);            // resume past breakpoint
    cmd(CMD_HALT, 16'd0);  idle(2);
    cmd(CMD_STEP, 16'd100); idle(5);
    cmd(CMD_HALT, 16'd0);  idle(3);            // aborted step
    bp_tmp = cpu_pc + PC_W'(3);
    cmd(CMD_SETBP, 16'h8000 | 16'(bp_tmp)); cmd(CMD_RUN, 16'd0); idle(3);
    cmd(CMD_HALT, 16'd0);  idle(2);            // HALT coincides with breakpoint
    cmd(CMD_SETBP, 16'h8005); cmd(CMD_RUN, 16'd0); idle(2);
    cmd(CMD_RESET, 16'd0); idle(5);
    cmd(CMD_RUN, 16'd0);   idle(10);           // breakpoint survives RESET
    cmd(CMD_STEP, 16'd50); idle(5);
    async_rst();           idle(6);
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 3);
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom_range(0, 31));
      if (op == 3'd3) a = 16'($urandom_range(0, 6));
      if (op == 3'd4 && $urandom_range(0, 1) == 1) a[15] = 1'b1;
      drive_cycle(v, op, a, $urandom_range(0, 1) == 1);
    end
    idle(2);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
